rx_align_ctrl: RTL



---
 rtl/rx_align_pkg.sv | 27 ++
 rtl/rx_align_wcnt.sv | 30 +++
 rtl/rx_align_ctrl.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/rx_align_pkg.sv
// Shared types and constants for the receive word-alignment controller.
// Defaults mirror a 10-bit 8b10b lane; K28.1 codes are for stimulus generation.
package rx_align_pkg;

  localparam int DSIZE_DEF        = 10;
  localparam int SETTLE_WORDS_DEF = 4;
  localparam int CHECK_WORDS_DEF  = 16;
  localparam int LOSS_ERRS_DEF    = 4;
  localparam int PHASE_W          = $clog2(DSIZE_DEF);

  localparam logic [9:0] K28_1_NEG = 10'b0011111001;
  localparam logic [9:0] K28_1_POS = 10'b1100000110;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SETTLE = 3'd1,
    ST_CHECK  = 3'd2,
    ST_SLIP   = 3'd3,
    ST_LOCKED = 3'd4,
    ST_FAIL   = 3'd5
  } state_t;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/rx_align_wcnt.sv
// Word-strobe counter with clear/load; tc flags the strobe that reaches term.
// tc is combinational from inc so the owner can act on the terminal strobe itself.
module rx_align_wcnt #(
  parameter int WIDTH = 8
) (
  input  logic             FCLK,
  input  logic             reset,
  input  logic             clear,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             inc,
  input  logic [WIDTH-1:0] term,
  output logic             tc
);

  logic [WIDTH-1:0] count;

  always_ff @(posedge FCLK) begin
    if (reset || clear) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (inc) begin
      count <= count + 1'b1;
    end
  end

  assign tc = inc && (count == term - 1'b1);

endmodule

// File: rtl/rx_align_ctrl.sv
// Bitslip sequencer: settle, qualify a window on err/comma, lock, monitor loss.
// All outputs registered; bitslip is a single-cycle pulse one cycle after the failed window.
module rx_align_ctrl
  import rx_align_pkg::*;
#(
  parameter int DSIZE        = DSIZE_DEF,
  parameter int SETTLE_WORDS = SETTLE_WORDS_DEF,
  parameter int CHECK_WORDS  = CHECK_WORDS_DEF,
  parameter int LOSS_ERRS    = LOSS_ERRS_DEF
) (
  input  logic                     FCLK,
  input  logic                     reset,
  input  logic                     enable,
  input  logic                     word_valid,
  input  logic                     decoder_err,
  input  logic                     comma_det,
  input  logic                     err_clear,
  output logic                     bitslip,
  output logic                     locked,
  output logic                     fail,
  output logic [$clog2(DSIZE)-1:0] phase,
  output logic [15:0]              err_count
);

  localparam int PW    = $clog2(DSIZE);
  localparam int TW    = $clog2(DSIZE + 1);
  localparam int WIN_W = $clog2(max2(SETTLE_WORDS, CHECK_WORDS) + 1);
  localparam int LW    = $clog2(LOSS_ERRS + 1);

  state_t         state_q, state_d;
  logic [TW-1:0]  tried_q;
  logic           any_err_q, any_comma_q;
  logic           win_clr, win_tc;
  logic [WIN_W-1:0] win_term;
  logic           loss_inc, loss_clr, loss_tc;
  logic           tried_clr, tried_inc, flag_clr;

  // One counter serves both the settle and check windows.
  assign win_term = (state_q == ST_SETTLE) ? WIN_W'(SETTLE_WORDS) : WIN_W'(CHECK_WORDS);

  rx_align_wcnt #(.WIDTH(WIN_W)) u_win_cnt (
    .FCLK     (FCLK),
    .reset    (reset),
    .clear    (win_clr),
    .load     (1'b0),
    .load_val ('0),
    .inc      (word_valid),
    .term     (win_term),
    .tc       (win_tc)
  );

  assign loss_inc = word_valid && decoder_err && (state_q == ST_LOCKED);
  assign loss_clr = (state_q != ST_LOCKED) || (word_valid && !decoder_err);

  rx_align_wcnt #(.WIDTH(LW)) u_loss_cnt (
    .FCLK     (FCLK),
    .reset    (reset),
    .clear    (loss_clr),
    .load     (1'b0),
    .load_val ('0),
    .inc      (loss_inc),
    .term     (LW'(LOSS_ERRS)),
    .tc       (loss_tc)
  );

  always_comb begin
    state_d   = state_q;
    win_clr   = 1'b0;
    tried_clr = 1'b0;
    tried_inc = 1'b0;
    flag_clr  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        win_clr   = 1'b1;
        flag_clr  = 1'b1;
        tried_clr = 1'b1;
        if (enable) state_d = ST_SETTLE;
      end
      ST_SETTLE: begin
        if (win_tc) begin
          state_d  = ST_CHECK;
          win_clr  = 1'b1;
          flag_clr = 1'b1;
        end
      end
      ST_CHECK: begin
        if (win_tc) begin
          win_clr = 1'b1;
          // The terminal word itself is part of the window.
          if (!(any_err_q || decoder_err) && (any_comma_q || comma_det)) begin
            state_d = ST_LOCKED;
          end else begin
            tried_inc = 1'b1;
            state_d   = (tried_q == TW'(DSIZE - 1)) ? ST_FAIL : ST_SLIP;
          end
        end
      end
      ST_SLIP: begin
        win_clr = 1'b1;
        state_d = ST_SETTLE;
      end
      ST_LOCKED: begin
        win_clr = 1'b1;
        if (loss_tc) begin
          state_d   = ST_SETTLE;
          tried_clr = 1'b1;
        end
      end
      ST_FAIL: begin
        win_clr = 1'b1;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    if (!enable) begin
      state_d = ST_IDLE;
      win_clr = 1'b1;
    end
  end

  always_ff @(posedge FCLK) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      tried_q     <= '0;
      any_err_q   <= 1'b0;
      any_comma_q <= 1'b0;
      bitslip     <= 1'b0;
      locked      <= 1'b0;
      fail        <= 1'b0;
      phase       <= '0;
      err_count   <= '0;
    end else begin
      state_q <= state_d;
      bitslip <= (state_d == ST_SLIP);
      locked  <= (state_d == ST_LOCKED);
      fail    <= (state_d == ST_FAIL);

      if (state_d == ST_SLIP) begin
        phase <= (phase == PW'(DSIZE - 1)) ? '0 : phase + 1'b1;
      end

      if (tried_clr) begin
        tried_q <= '0;
      end else if (tried_inc) begin
        tried_q <= tried_q + 1'b1;
      end

      if (flag_clr) begin
        any_err_q   <= 1'b0;
        any_comma_q <= 1'b0;
      end else if (state_q == ST_CHECK && word_valid) begin
        any_err_q   <= any_err_q | decoder_err;
        any_comma_q <= any_comma_q | comma_det;
      end

      // Clear wins over a coincident error word; lock loss leaves the count alone.
      if (err_clear) begin
        err_count <= '0;
      end else if (state_q == ST_LOCKED && word_valid && decoder_err &&
                   err_count != 16'hFFFF) begin
        err_count <= err_count + 16'd1;
      end
    end
  end

endmodule
